alu_vector_checker: RTL and testbench

Synthesizable, self-running vector generator and checker for the 10-bit two-operand ALU used in the lab exercises. It is the driving end of the ALU's `a`/`b`/`mode` → `y`/`is_zero` interface. It sweeps the standard complementary-operand vector set through all four modes and compares `y` against an internal reference model. It reports pass/fail, an error count and the first failing vector, so the ALU can be checked on the board without a simulator.

---
 rtl/alu_vector_checker_pkg.sv | 30 +++
 rtl/alu_vector_checker_if.sv | 37 +++
 rtl/alu_vector_checker_ref_model.sv | 37 +++
 rtl/alu_vector_checker.sv | 184 ++++++++++++++++++
 tb/tb_alu_vector_checker.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_vector_checker_pkg.sv
//============================================================================
// Module   : alu_chk_pkg
// Desc     : Shared types and constants for the ALU vector checker: FSM
//            state encoding, ALU mode codes and error counter width.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package alu_chk_pkg;

  // Checker sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // ALU operation codes driven on the mode bus
  localparam logic [1:0] MODE_A   = 2'd0;
  localparam logic [1:0] MODE_B   = 2'd1;
  localparam logic [1:0] MODE_ADD = 2'd2;
  localparam logic [1:0] MODE_SUB = 2'd3;

  // Width of the saturating mismatch counter
  localparam int c_err_w = 16;

endpackage

`default_nettype wire

// File: rtl/alu_vector_checker_if.sv
//============================================================================
// Module   : alu_vector_checker_if
// Desc     : Operand/result bundle between the vector checker (master) and
//            the ALU under test (slave).
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

interface alu_vector_checker_if #(
  parameter int WIDTH = 10
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       mode;
  logic [WIDTH-1:0] y;
  logic             is_zero;

  modport master (
    output a,
    output b,
    output mode,
    input  y,
    input  is_zero
  );

  modport slave (
    input  a,
    input  b,
    input  mode,
    output y,
    output is_zero
  );

endinterface

`default_nettype wire

// File: rtl/alu_vector_checker_ref_model.sv
//============================================================================
// Module   : alu_ref_model
// Desc     : Combinational golden ALU: result modulo 2^WIDTH (carry/borrow
//            dropped) and the matching zero flag.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module alu_ref_model
  import alu_chk_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] expected_y,
  output logic             expected_zero
);

  // Select the golden result for the requested operation
  always_comb begin
    expected_y = a;
    case (mode)
      MODE_A:   expected_y = a;
      MODE_B:   expected_y = b;
      MODE_ADD: expected_y = a + b;
      MODE_SUB: expected_y = a - b;
      default:  expected_y = a;
    endcase
  end

  assign expected_zero = (expected_y == '0);

endmodule

`default_nettype wire

// File: rtl/alu_vector_checker.sv
//============================================================================
// Module   : alu_vector_checker
// Desc     : Self-running sweep of complementary operand pairs through all
//            four ALU modes; compares y with a golden model and reports
//            pass/fail, a saturating error count and the first failure.
//            Optional macro ALU_CHK_ZERO_EN also checks the is_zero flag.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module alu_vector_checker
  import alu_chk_pkg::*;
#(
  parameter int WIDTH         = 10,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  alu_vector_checker_if.master alu,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [c_err_w-1:0]   error_count,
  output logic                 first_fail_valid,
  output logic [WIDTH-1:0]     first_fail_a,
  output logic [1:0]           first_fail_mode,
  output logic [WIDTH-1:0]     first_fail_y
);

  localparam int c_cnt_w = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(SETTLE_CYCLES - 1);
  // Final operand A of the sweep is 2^WIDTH-2
  localparam logic [WIDTH-1:0] c_last_a = {{(WIDTH-1){1'b1}}, 1'b0};

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_launch;
  logic                 w_last_vec;
  logic                 w_fail;
  logic [WIDTH-1:0]     w_exp_y;
  logic                 w_exp_zero;

  logic [c_cnt_w-1:0]   r_settle_cnt;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [1:0]           r_mode;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_pass;
  logic [c_err_w-1:0]   r_err;
  logic                 r_ff_valid;
  logic [WIDTH-1:0]     r_ff_a;
  logic [1:0]           r_ff_mode;
  logic [WIDTH-1:0]     r_ff_y;

  alu_ref_model #(
    .WIDTH(WIDTH)
  ) u_ref (
    .a             (r_a),
    .b             (r_b),
    .mode          (r_mode),
    .expected_y    (w_exp_y),
    .expected_zero (w_exp_zero)
  );

`ifdef ALU_CHK_ZERO_EN
  // A vector fails once even when both result and flag are wrong
  assign w_fail = (alu.y != w_exp_y) || (alu.is_zero != w_exp_zero);
`else
  logic w_unused_zero;
  assign w_unused_zero = alu.is_zero ^ w_exp_zero;
  assign w_fail        = (alu.y != w_exp_y);
`endif

  assign w_last_vec = (r_a == c_last_a) && (r_mode == MODE_SUB);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and sweep launch strobe
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_nxt = SETTLE;
          w_launch    = 1'b1;
        end
      end
      SETTLE: begin
        if (r_settle_cnt == c_settle_last) begin
          w_state_nxt = CHECK;
        end
      end
      CHECK: begin
        w_state_nxt = w_last_vec ? DONE : SETTLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Vector generation, result checking and status registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_settle_cnt <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_mode       <= MODE_A;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err        <= '0;
      r_ff_valid   <= 1'b0;
      r_ff_a       <= '0;
      r_ff_mode    <= MODE_A;
      r_ff_y       <= '0;
    end else if (w_launch) begin
      r_settle_cnt <= '0;
      r_a          <= '0;
      r_b          <= '1;
      r_mode       <= MODE_A;
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err        <= '0;
      r_ff_valid   <= 1'b0;
      r_ff_a       <= '0;
      r_ff_mode    <= MODE_A;
      r_ff_y       <= '0;
    end else if (r_state == SETTLE) begin
      r_settle_cnt <= r_settle_cnt + c_cnt_w'(1);
    end else if (r_state == CHECK) begin
      r_settle_cnt <= '0;
      if (w_fail) begin
        if (r_err != '1) begin
          r_err <= r_err + c_err_w'(1);
        end
        if (!r_ff_valid) begin
          r_ff_valid <= 1'b1;
          r_ff_a     <= r_a;
          r_ff_mode  <= r_mode;
          r_ff_y     <= alu.y;
        end
      end
      if (w_last_vec) begin
        // Operands are left on the last vector; only status changes
        r_busy <= 1'b0;
        r_done <= 1'b1;
        r_pass <= !w_fail && (r_err == '0);
      end else if (r_mode == MODE_SUB) begin
        r_a    <= r_a + WIDTH'(1);
        r_b    <= r_b - WIDTH'(1);
        r_mode <= MODE_A;
      end else begin
        r_mode <= r_mode + 2'd1;
      end
    end
  end

  assign alu.a            = r_a;
  assign alu.b            = r_b;
  assign alu.mode         = r_mode;
  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign error_count      = r_err;
  assign first_fail_valid = r_ff_valid;
  assign first_fail_a     = r_ff_a;
  assign first_fail_mode  = r_ff_mode;
  assign first_fail_y     = r_ff_y;

endmodule

`default_nettype wire

// File: tb/tb_alu_vector_checker.sv
//============================================================================
// Module   : tb_alu_vector_checker
// Desc     : Self-checking bench for alu_vector_checker with a behavioural
//            ALU (selectable faults) and a sweep-level reference model.
//            Honours ALU_CHK_ZERO_EN for the is_zero scenario.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_alu_vector_checker;
  import alu_chk_pkg::*;

  localparam int WIDTH  = 10;
  localparam int SETTLE = 2;
  localparam int MASK   = (1 << WIDTH) - 1;
  localparam int NPAIRS = (1 << WIDTH) - 1;
  localparam int NVEC   = 4 * NPAIRS;
  localparam int SWEEP  = NVEC * (SETTLE + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;

  logic             busy, done, pass, ff_valid;
  logic [15:0]      error_count;
  logic [WIDTH-1:0] ff_a, ff_y;
  logic [1:0]       ff_mode;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // ALU fault configuration: 0 ok, 1 sub returns add, 2 y stuck 0, 3 random
  int  fault_sel = 0;
  bit  zero_tie0 = 1'b0;
  int  fr_mod    = 7;
  int  fr_rem    = 0;
  int  fr_mode   = 0;
  int  fr_mask   = 1;

  always #5 clk = ~clk;

  alu_vector_checker_if #(.WIDTH(WIDTH)) bus ();

  alu_vector_checker #(
    .WIDTH         (WIDTH),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .alu              (bus),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .error_count      (error_count),
    .first_fail_valid (ff_valid),
    .first_fail_a     (ff_a),
    .first_fail_mode  (ff_mode),
    .first_fail_y     (ff_y)
  );

  function automatic int spec_y(int a, int b, int m);
    case (m)
      0:       return a;
      1:       return b;
      2:       return (a + b) & MASK;
      default: return (a - b) & MASK;
    endcase
  endfunction

  function automatic int alu_y(int a, int b, int m);
    case (fault_sel)
      1:       return (m == 3) ? ((a + b) & MASK) : spec_y(a, b, m);
      2:       return 0;
      3:       return (m == fr_mode && (a % fr_mod) == fr_rem) ?
                      (spec_y(a, b, m) ^ fr_mask) : spec_y(a, b, m);
      default: return spec_y(a, b, m);
    endcase
  endfunction

  function automatic bit alu_z(int a, int b, int m);
    return zero_tie0 ? 1'b0 : (alu_y(a, b, m) == 0);
  endfunction

  // Behavioural ALU under test
  always_comb begin
    bus.y       = WIDTH'(alu_y(int'(bus.a), int'(bus.b), int'(bus.mode)));
    bus.is_zero = alu_z(int'(bus.a), int'(bus.b), int'(bus.mode));
  end

  // Sweep-level model: vector n = k/(SETTLE+1), a = n/4, mode = n%4
  bit m_active = 0;
  int m_k = 0, m_n = 0;
  int m_busy = 0, m_done = 0, m_pass = 0, m_err = 0;
  int m_ffv = 0, m_ffa = 0, m_ffm = 0, m_ffy = 0;
  int m_a = 0, m_b = 0, m_mode = 0;
  int v_a, v_b, v_m, v_y;
  bit v_bad;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_active = 0; m_k = 0; m_busy = 0; m_done = 0; m_pass = 0; m_err = 0;
      m_ffv = 0; m_ffa = 0; m_ffm = 0; m_ffy = 0; m_a = 0; m_b = 0; m_mode = 0;
    end else if (m_active) begin
      m_k++;
      if (m_k % (SETTLE + 1) == 0) begin
        m_n   = m_k / (SETTLE + 1) - 1;
        v_a   = m_n / 4;
        v_m   = m_n % 4;
        v_b   = NPAIRS - v_a;
        v_y   = alu_y(v_a, v_b, v_m);
        v_bad = (v_y != spec_y(v_a, v_b, v_m));
`ifdef ALU_CHK_ZERO_EN
        if (alu_z(v_a, v_b, v_m) != (spec_y(v_a, v_b, v_m) == 0)) v_bad = 1'b1;
`endif
        if (v_bad) begin
          if (m_err < 65535) m_err++;
          if (m_ffv == 0) begin
            m_ffv = 1; m_ffa = v_a; m_ffm = v_m; m_ffy = v_y;
          end
        end
        if (m_n == NVEC - 1) begin
          m_active = 0; m_busy = 0; m_done = 1; m_pass = (m_err == 0);
        end else begin
          m_a = (m_n + 1) / 4; m_mode = (m_n + 1) % 4; m_b = NPAIRS - m_a;
        end
      end
    end else if (start) begin
      m_active = 1; m_k = 0; m_busy = 1; m_done = 0; m_pass = 0; m_err = 0;
      m_ffv = 0; m_ffa = 0; m_ffm = 0; m_ffy = 0; m_a = 0; m_b = NPAIRS; m_mode = 0;
    end
  end

  // Cycle-by-cycle comparison of every DUT output against the model
  logic [63:0] cmp_exp, cmp_act;
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_exp = {1'(m_busy), 1'(m_done), 1'(m_pass), 16'(m_err), 1'(m_ffv),
                 10'(m_ffa), 2'(m_ffm), 10'(m_ffy), 10'(m_a), 10'(m_b), 2'(m_mode)};
      cmp_act = {busy, done, pass, error_count, ff_valid, ff_a, ff_mode, ff_y,
                 bus.a, bus.b, bus.mode};
      checks++;
      if (cmp_act !== cmp_exp) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, cmp_act, cmp_exp);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_sweep(input bit noisy, output int cyc);
    start_pulse();
    cyc = 0;
    while (cyc < SWEEP + 100) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done) break;
      if (noisy) start = ($urandom_range(0, 15) == 0);
    end
    start = 1'b0;
    chk("sweep_completes", int'(done), 1);
  endtask

  int cyc;
  int exp_cnt;

  initial begin
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_b", int'(bus.b), 0);
    chk("reset_state", int'(dut.r_state), int'(IDLE));
    rst_n = 1'b1;

    // Correct ALU
    run_sweep(1'b0, cyc);
    chk("t1_cycles", cyc, 12276);
    chk("t1_pass", int'(pass), 1);
    chk("t1_err", int'(error_count), 0);
    chk("t1_ffv", int'(ff_valid), 0);

    // Subtract returns sum
    fault_sel = 1;
    run_sweep(1'b0, cyc);
    chk("t2_err", int'(error_count), 1022);
    chk("t2_ff_a", int'(ff_a), 0);
    chk("t2_ff_mode", int'(ff_mode), 3);
    chk("t2_ff_y", int'(ff_y), 1023);
    chk("t2_pass", int'(pass), 0);

    // Result stuck at zero
    fault_sel = 2;
    run_sweep(1'b0, cyc);
    chk("t3_err", int'(error_count), 4091);
    chk("t3_ff_a", int'(ff_a), 0);
    chk("t3_ff_mode", int'(ff_mode), 1);
    chk("t3_ff_y", int'(ff_y), 0);

    // Start from DONE clears results, then reset mid-sweep
    fault_sel = 0;
    start_pulse();
    chk("t5_clear_err", int'(error_count), 0);
    chk("t5_clear_ffv", int'(ff_valid), 0);
    chk("t5_clear_done", int'(done), 0);
    chk("t5_busy", int'(busy), 1);
    repeat (99) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t4_rst_busy", int'(busy), 0);
    chk("t4_rst_a", int'(bus.a), 0);
    chk("t4_rst_state", int'(dut.r_state), int'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh sweep with start noise while busy
    run_sweep(1'b1, cyc);
    chk("t4_cycles", cyc, 12276);
    chk("t4_pass", int'(pass), 1);

    // Randomized sparse corruption
    fault_sel = 3;
    fr_mod    = $urandom_range(3, 40);
    fr_rem    = $urandom_range(0, fr_mod - 1);
    fr_mode   = $urandom_range(0, 3);
    fr_mask   = $urandom_range(1, MASK);
    exp_cnt = 0;
    for (int i = 0; i < NPAIRS; i++) if (i % fr_mod == fr_rem) exp_cnt++;
    run_sweep(1'b1, cyc);
    chk("rnd_err", int'(error_count), exp_cnt);
    chk("rnd_ff_a", int'(ff_a), fr_rem);
    chk("rnd_ff_mode", int'(ff_mode), fr_mode);
    chk("rnd_ff_y", int'(ff_y), spec_y(fr_rem, NPAIRS - fr_rem, fr_mode) ^ fr_mask);

    // Correct result, zero flag tied low
    fault_sel = 0;
    zero_tie0 = 1'b1;
    run_sweep(1'b0, cyc);
`ifdef ALU_CHK_ZERO_EN
    chk("t6_err", int'(error_count), 1);
    chk("t6_ff_a", int'(ff_a), 0);
    chk("t6_ff_mode", int'(ff_mode), 0);
`else
    chk("t6_pass", int'(pass), 1);
    chk("t6_err", int'(error_count), 0);
`endif

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
